// File: rtl/uart_cmd_bridge_if.sv
// uart_cmd_bridge_if
//   Command/response channel between a host and uart_cmd_bridge.
//   cmd        : command packet (MSB = write(1)/read(0), header in top bytes,
//                payload in low DATA_BYTES bytes)
//   uart_valid : host presents a command
//   uart_ready : bridge can take a command
//   read_data  : assembled read response
//   read_valid : one-cycle pulse, read_data/read_err valid
//   read_err   : the read response timed out
//   master = host side, slave = bridge side.
interface uart_cmd_bridge_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CMD_BYTES  = 2,
  parameter int DATA_BYTES = 1
);
  logic [CMD_BYTES*DATA_WIDTH-1:0]  cmd;
  logic                             uart_valid;
  logic                             uart_ready;
  logic [DATA_BYTES*DATA_WIDTH-1:0] read_data;
  logic                             read_valid;
  logic                             read_err;

  modport master (
    output cmd, uart_valid,
    input  uart_ready, read_data, read_valid, read_err
  );

  modport slave (
    input  cmd, uart_valid,
    output uart_ready, read_data, read_valid, read_err
  );
endinterface

// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge
//   Serialises a command packet onto a byte-wide UART transmitter, most
//   significant byte first. Writes send the whole packet; reads send only the
//   header and then collect DATA_BYTES response bytes from the receiver, with a
//   per-byte timeout.
//   clk, rst_n        : single clock, asynchronous active-low reset
//   bus (slave)       : command in, read response out
//   tx_data / tx_en   : byte and one-cycle send strobe to the transmitter
//   tx_done           : transmitter finished the byte (pulse)
//   rx_data / rx_done : received byte and its one-cycle valid pulse
module uart_cmd_bridge #(
  parameter int DATA_WIDTH     = 8,
  parameter int CMD_BYTES      = 2,
  parameter int DATA_BYTES     = 1,
  parameter int TIMEOUT_CYCLES = 50_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_cmd_bridge_if.slave       bus,
  output logic [DATA_WIDTH-1:0]  tx_data,
  output logic                   tx_en,
  input  logic                   tx_done,
  input  logic [DATA_WIDTH-1:0]  rx_data,
  input  logic                   rx_done
);

  localparam int HDR_BYTES = CMD_BYTES - DATA_BYTES;
  localparam int CW        = CMD_BYTES * DATA_WIDTH;
  localparam int RW        = DATA_BYTES * DATA_WIDTH;
  localparam int CNT_W     = $clog2(CMD_BYTES + 1);
  localparam int TO_W      = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [CNT_W-1:0] CNT_WR   = CNT_W'(CMD_BYTES);
  localparam logic [CNT_W-1:0] CNT_RD   = CNT_W'(HDR_BYTES);
  localparam logic [CNT_W-1:0] CNT_RESP = CNT_W'(DATA_BYTES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [TO_W-1:0]  TO_ZERO  = TO_W'(0);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SEND    = 2'd1;
  localparam logic [1:0] S_WAIT_TX = 2'd2;
  localparam logic [1:0] S_WAIT_RX = 2'd3;

  logic [1:0]            state_q,     state_d;
  logic [CW-1:0]         shift_q,     shift_d;
  logic                  wr_q,        wr_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [TO_W-1:0]       to_q,        to_d;
  logic [RW-1:0]         resp_q,      resp_d;
  logic [DATA_WIDTH-1:0] tx_data_q,   tx_data_d;
  logic                  tx_en_q,     tx_en_d;
  logic [RW-1:0]         rd_data_q,   rd_data_d;
  logic                  rd_valid_q,  rd_valid_d;
  logic                  rd_err_q,    rd_err_d;

  logic [CNT_W-1:0]      cnt_dec;
  logic [RW-1:0]         resp_next;

  assign cnt_dec   = cnt_q - CNT_ONE;
  // First received byte ends up most significant once all bytes are in.
  assign resp_next = (resp_q << DATA_WIDTH) | RW'(rx_data);

  // Next-state and datapath decisions for the bridge FSM.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    resp_d     = resp_q;
    tx_data_d  = tx_data_q;
    tx_en_d    = 1'b0;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_err_d   = rd_err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.uart_valid) begin
          // tx_en/tx_data are loaded on entry so the strobe lines up with SEND.
          state_d   = S_SEND;
          wr_d      = bus.cmd[CW-1];
          cnt_d     = bus.cmd[CW-1] ? CNT_WR : CNT_RD;
          tx_data_d = bus.cmd[CW-1 -: DATA_WIDTH];
          shift_d   = bus.cmd << DATA_WIDTH;
          tx_en_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SEND: begin
        state_d = S_WAIT_TX;
      end

      S_WAIT_TX: begin
        if (tx_done) begin
          cnt_d = cnt_dec;
          if (cnt_dec != CNT_ZERO) begin
            state_d   = S_SEND;
            tx_data_d = shift_q[CW-1 -: DATA_WIDTH];
            shift_d   = shift_q << DATA_WIDTH;
            tx_en_d   = 1'b1;
          end else if (wr_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_RX;
            cnt_d   = CNT_RESP;
            to_d    = TO_ZERO;
            resp_d  = {RW{1'b0}};
          end
        end else begin
          state_d = S_WAIT_TX;
        end
      end

      S_WAIT_RX: begin
        // A byte arriving on the last allowed cycle still counts as success.
        if (rx_done) begin
          resp_d = resp_next;
          cnt_d  = cnt_dec;
          to_d   = TO_ZERO;
          if (cnt_q == CNT_ONE) begin
            state_d    = S_IDLE;
            rd_data_d  = resp_next;
            rd_valid_d = 1'b1;
            rd_err_d   = 1'b0;
          end else begin
            state_d = S_WAIT_RX;
          end
        end else if (to_q == TO_LAST) begin
          state_d    = S_IDLE;
          to_d       = TO_ZERO;
          rd_data_d  = {RW{1'b0}};
          rd_valid_d = 1'b1;
          rd_err_d   = 1'b1;
        end else begin
          state_d = S_WAIT_RX;
          to_d    = to_q + TO_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= {CW{1'b0}};
      wr_q       <= 1'b0;
      cnt_q      <= CNT_ZERO;
      to_q       <= TO_ZERO;
      resp_q     <= {RW{1'b0}};
      tx_data_q  <= {DATA_WIDTH{1'b0}};
      tx_en_q    <= 1'b0;
      rd_data_q  <= {RW{1'b0}};
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      resp_q     <= resp_d;
      tx_data_q  <= tx_data_d;
      tx_en_q    <= tx_en_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign bus.uart_ready = (state_q == S_IDLE);
  assign bus.read_data  = rd_data_q;
  assign bus.read_valid = rd_valid_q;
  assign bus.read_err   = rd_err_q;
  assign tx_data        = tx_data_q;
  assign tx_en          = tx_en_q;

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// tb_uart_cmd_bridge
//   Two bridge instances: a 2-byte command / 1-byte payload bridge and a
//   4-byte command / 2-byte payload bridge, both with a 16-cycle timeout.
//   Expected transmitted bytes and read responses are queued when a command is
//   issued and checked when the bridge produces them.
module tb_uart_cmd_bridge;

  logic clk;
  logic rst_n;

  uart_cmd_bridge_if #(.DATA_WIDTH(8), .CMD_BYTES(2), .DATA_BYTES(1)) bus0 ();
  uart_cmd_bridge_if #(.DATA_WIDTH(8), .CMD_BYTES(4), .DATA_BYTES(2)) bus1 ();

  logic [7:0] tx_data0, rx_data0, tx_data1, rx_data1;
  logic       tx_en0, tx_done0, rx_done0, tx_en1, tx_done1, rx_done1;

  uart_cmd_bridge #(.DATA_WIDTH(8), .CMD_BYTES(2), .DATA_BYTES(1), .TIMEOUT_CYCLES(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .tx_data(tx_data0), .tx_en(tx_en0), .tx_done(tx_done0),
    .rx_data(rx_data0), .rx_done(rx_done0)
  );

  uart_cmd_bridge #(.DATA_WIDTH(8), .CMD_BYTES(4), .DATA_BYTES(2), .TIMEOUT_CYCLES(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .tx_data(tx_data1), .tx_en(tx_en1), .tx_done(tx_done1),
    .rx_data(rx_data1), .rx_done(rx_done1)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0]  txq0[$];
  logic [7:0]  txq1[$];
  logic [31:0] rdq0[$];
  logic [31:0] rdq1[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every transmitted byte and read response as it appears.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_en0) begin
        chk("tx0_pending", 32'(txq0.size() != 0), 32'd1);
        if (txq0.size() != 0) chk("tx0_byte", 32'(tx_data0), 32'(txq0.pop_front()));
      end
      if (bus0.read_valid) begin
        chk("rd0_pending", 32'(rdq0.size() != 0), 32'd1);
        if (rdq0.size() != 0) chk("rd0_resp", {23'd0, bus0.read_err, bus0.read_data}, rdq0.pop_front());
      end
      if (tx_en1) begin
        chk("tx1_pending", 32'(txq1.size() != 0), 32'd1);
        if (txq1.size() != 0) chk("tx1_byte", 32'(tx_data1), 32'(txq1.pop_front()));
      end
      if (bus1.read_valid) begin
        chk("rd1_pending", 32'(rdq1.size() != 0), 32'd1);
        if (rdq1.size() != 0) chk("rd1_resp", {15'd0, bus1.read_err, bus1.read_data}, rdq1.pop_front());
      end
    end
  end

  // ---------------- instance 0 helpers (call just after a rising edge) -------
  task automatic issue0(input logic [15:0] c);
    chk("rdy0_idle", 32'(bus0.uart_ready), 32'd1);
    bus0.cmd = c;
    bus0.uart_valid = 1'b1;
    @(posedge clk);
    #1 bus0.uart_valid = 1'b0;
    chk("rdy0_busy", 32'(bus0.uart_ready), 32'd0);
  endtask

  task automatic wait_tx0();
    bit got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (tx_en0) begin
        got = 1'b1;
        break;
      end
    end
    chk("tx0_seen", 32'(got), 32'd1);
  endtask

  task automatic tx_ack0(input int lat);
    repeat (lat) @(posedge clk);
    #1 tx_done0 = 1'b1;
    @(posedge clk);
    #1 tx_done0 = 1'b0;
  endtask

  task automatic rx_byte0(input logic [7:0] b);
    rx_data0 = b;
    rx_done0 = 1'b1;
    @(posedge clk);
    #1 rx_done0 = 1'b0;
  endtask

  // ---------------- instance 1 helpers --------------------------------------
  task automatic issue1(input logic [31:0] c);
    chk("rdy1_idle", 32'(bus1.uart_ready), 32'd1);
    bus1.cmd = c;
    bus1.uart_valid = 1'b1;
    @(posedge clk);
    #1 bus1.uart_valid = 1'b0;
  endtask

  task automatic wait_tx1();
    bit got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (tx_en1) begin
        got = 1'b1;
        break;
      end
    end
    chk("tx1_seen", 32'(got), 32'd1);
  endtask

  task automatic tx_ack1(input int lat);
    repeat (lat) @(posedge clk);
    #1 tx_done1 = 1'b1;
    @(posedge clk);
    #1 tx_done1 = 1'b0;
  endtask

  initial begin
    int n;
    bit seen;
    rst_n = 1'b1;
    bus0.cmd = 16'h0000; bus0.uart_valid = 1'b0;
    bus1.cmd = 32'h0;    bus1.uart_valid = 1'b0;
    tx_done0 = 1'b0; rx_done0 = 1'b0; rx_data0 = 8'h00;
    tx_done1 = 1'b0; rx_done1 = 1'b0; rx_data1 = 8'h00;

    // Reset values appear without any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready",  32'(bus0.uart_ready), 32'd1);
    chk("rst_tx_en",  32'(tx_en0),          32'd0);
    chk("rst_tx_dat", 32'(tx_data0),        32'd0);
    chk("rst_rvalid", 32'(bus0.read_valid), 32'd0);
    chk("rst_rerr",   32'(bus0.read_err),   32'd0);
    chk("rst_rdata",  32'(bus0.read_data),  32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write: both bytes go out, ready returns right after the last tx_done.
    txq0.push_back(8'hA5); txq0.push_back(8'h3C);
    issue0(16'hA53C);
    wait_tx0();
    tx_ack0(2);
    wait_tx0();
    chk("rdy0_mid_wr", 32'(bus0.uart_ready), 32'd0);
    tx_ack0(3);
    chk("rdy0_after_wr", 32'(bus0.uart_ready), 32'd1);

    // Read: header byte out, stray tx_done while awaiting response, then reply.
    txq0.push_back(8'h12); rdq0.push_back(32'h07E);
    issue0(16'h1200);
    wait_tx0();
    tx_ack0(1);
    repeat (2) @(posedge clk);
    #1 tx_done0 = 1'b1;
    @(posedge clk);
    #1 tx_done0 = 1'b0;
    rx_byte0(8'h7E);
    chk("rv0_high", 32'(bus0.read_valid), 32'd1);
    @(posedge clk); #1;
    chk("rv0_pulse", 32'(bus0.read_valid), 32'd0);
    chk("rd0_hold", 32'(bus0.read_data), 32'h7E);
    chk("rdy0_after_rd", 32'(bus0.uart_ready), 32'd1);

    // Stray rx_done while idle changes nothing.
    rx_byte0(8'h55);
    repeat (2) @(posedge clk); #1;
    chk("rd0_stray", 32'(bus0.read_data), 32'h7E);
    chk("rv0_stray", 32'(bus0.read_valid), 32'd0);
    chk("rdy0_stray", 32'(bus0.uart_ready), 32'd1);

    // Timeout: error response 16 cycles after the header tx_done.
    txq0.push_back(8'h34); rdq0.push_back(32'h100);
    issue0(16'h3400);
    wait_tx0();
    tx_ack0(1);
    n = 0; seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      n++;
      if (bus0.read_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("to0_seen", 32'(seen), 32'd1);
    chk("to0_lat", 32'(n), 32'd16);
    @(posedge clk); #1;
    chk("to0_err_hold", 32'(bus0.read_err), 32'd1);
    chk("to0_rdy", 32'(bus0.uart_ready), 32'd1);

    // rx_done on the timeout cycle wins.
    txq0.push_back(8'h56); rdq0.push_back(32'h09A);
    issue0(16'h5600);
    wait_tx0();
    tx_ack0(1);
    repeat (15) @(posedge clk);
    #1 rx_byte0(8'h9A);
    chk("race0_rv", 32'(bus0.read_valid), 32'd1);
    chk("race0_err", 32'(bus0.read_err), 32'd0);
    @(posedge clk); #1;

    // Reset in WAIT_TX of a write abandons it; next command runs normally.
    txq0.push_back(8'h8F);
    issue0(16'h8FF0);
    wait_tx0();
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ready",  32'(bus0.uart_ready), 32'd1);
    chk("mrst_tx_en",  32'(tx_en0),          32'd0);
    chk("mrst_tx_dat", 32'(tx_data0),        32'd0);
    chk("mrst_rvalid", 32'(bus0.read_valid), 32'd0);
    chk("mrst_rerr",   32'(bus0.read_err),   32'd0);
    chk("mrst_rdata",  32'(bus0.read_data),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    txq0.push_back(8'hC1); txq0.push_back(8'h22);
    issue0(16'hC122);
    wait_tx0();
    tx_ack0(1);
    wait_tx0();
    tx_ack0(1);
    chk("rdy0_post_rst", 32'(bus0.uart_ready), 32'd1);

    // Wide bridge: 2-byte header, 2-byte response assembled MSB first.
    txq1.push_back(8'h01); txq1.push_back(8'h02); rdq1.push_back(32'h0ABCD);
    issue1(32'h0102BEEF);
    wait_tx1();
    tx_ack1(1);
    wait_tx1();
    tx_ack1(2);
    rx_data1 = 8'hAB; rx_done1 = 1'b1;
    @(posedge clk); #1 rx_done1 = 1'b0;
    @(posedge clk); #1;
    chk("rv1_partial", 32'(bus1.read_valid), 32'd0);
    rx_data1 = 8'hCD; rx_done1 = 1'b1;
    @(posedge clk); #1 rx_done1 = 1'b0;
    chk("rv1_high", 32'(bus1.read_valid), 32'd1);
    @(posedge clk); #1;

    // Wide bridge write: all four bytes, no response.
    txq1.push_back(8'h88); txq1.push_back(8'h99);
    txq1.push_back(8'hAA); txq1.push_back(8'hBB);
    issue1(32'h8899AABB);
    for (int b = 0; b < 4; b++) begin
      wait_tx1();
      tx_ack1(1);
    end
    chk("rdy1_after_wr", 32'(bus1.uart_ready), 32'd1);

    repeat (3) @(posedge clk); #1;
    chk("txq0_drain", 32'(txq0.size()), 32'd0);
    chk("rdq0_drain", 32'(rdq0.size()), 32'd0);
    chk("txq1_drain", 32'(txq1.size()), 32'd0);
    chk("rdq1_drain", 32'(rdq1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/uart_cmd_bridge.md
UART_CMD_BRIDGE -- requirements
Module: uart_cmd_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: UART byte width in bits.
REQ-002 SHALL have parameter CMD_BYTES, default 2: command packet length in bytes, ≥2.
REQ-003 SHALL have parameter DATA_BYTES, default 1: payload bytes per command/response; HDR_BYTES = CMD_BYTES-DATA_BYTES, ≥1.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 50_000: clk cycles allowed per awaited response byte.
REQ-005 SHALL have port clk  in  1: system clock; the single clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-007 SHALL have port cmd  in  CMD_BYTES*DATA_WIDTH: packet; MSB = write(1)/read(0), header = top HDR_BYTES bytes, payload = low DATA_BYTES bytes.
REQ-008 SHALL have port uart_valid  in  1: cmd valid.
REQ-009 SHALL have port uart_ready  out  1: bridge can accept cmd.
REQ-010 SHALL have port tx_data  out  DATA_WIDTH: byte to transmitter.
REQ-011 SHALL have port tx_en  out  1: one-cycle send strobe.
REQ-012 SHALL have port tx_done  in  1: transmitter finished byte; one-cycle pulse.
REQ-013 SHALL have port rx_data  in  DATA_WIDTH: received byte.
REQ-014 SHALL have port rx_done  in  1: rx_data valid; one-cycle pulse, synchronous to clk.
REQ-015 SHALL have port read_data  out  DATA_BYTES*DATA_WIDTH: assembled read response.
REQ-016 SHALL have port read_valid  out  1: one-cycle pulse, read_data/read_err valid.
REQ-017 SHALL have port read_err  out  1: response timed out.

Function
REQ-018 SHALL implement FSM IDLE, SEND, WAIT_TX, WAIT_RX, all transitions on clk.
REQ-019 SHALL assert uart_ready only in IDLE; accept on uart_valid&&uart_ready, capturing cmd into a shift register and byte count = CMD_BYTES (write) or HDR_BYTES (read); next state SEND.
REQ-020 SHALL in SEND drive tx_data = current most-significant unsent byte (registered, held stable until the next SEND) and pulse tx_en for exactly one cycle; next state WAIT_TX.
REQ-021 SHALL in WAIT_TX on tx_done decrement the byte count; if count remaining → SEND; else write → IDLE, read → WAIT_RX with response byte count = DATA_BYTES and timeout counter cleared.
REQ-022 SHALL ignore tx_done outside WAIT_TX and ignore uart_valid outside IDLE.
REQ-023 SHALL in WAIT_RX on rx_done shift rx_data into the response register from the LSB end (first byte ends most significant), decrement the count and clear the timeout counter.
REQ-024 SHALL on the final rx_done drive read_data with the full response, pulse read_valid with read_err=0 the following cycle, and return to IDLE.
REQ-025 SHALL increment the timeout counter each WAIT_RX cycle without rx_done; on reaching TIMEOUT_CYCLES-1, pulse read_valid with read_err=1, read_data=0, return to IDLE.
REQ-026 SHALL give rx_done priority over timeout when both occur in the same cycle.
REQ-027 SHALL discard rx_done outside WAIT_RX with no output change.
REQ-028 SHALL hold read_data stable between read_valid pulses; read_err holds until the next read_valid.
REQ-029 SHALL size the timeout counter as $clog2(TIMEOUT_CYCLES)+1 bits; no wrap-around reachable.
REQ-030 SHALL need min. cycle counts: write command CMD_BYTES*2 + tx latency; uart_ready returns the cycle after final tx_done.

Reset
REQ-031 SHALL on rst_n low immediately: state IDLE, uart_ready=1, tx_en=0, tx_data=0, read_valid=0, read_err=0, read_data=0, all counters and shift registers 0.
REQ-032 SHALL abandon any in-flight command on mid-operation reset; no read_valid is emitted for it.

Verification
REQ-033 SHALL verify write: cmd=16'hA5_3C, valid → tx_en pulses with tx_data 8'hA5 then 8'h3C, no read_valid, uart_ready back after second tx_done.
REQ-034 SHALL verify read: cmd=16'h12_00 → one tx_en with 8'h12; rx_done with 8'h7E → read_valid one cycle, read_data=8'h7E, read_err=0.
REQ-035 SHALL verify timeout: TIMEOUT_CYCLES=16, read cmd, no rx_done → read_valid with read_err=1, read_data=0 16 cycles after the tx_done; IDLE.
REQ-036 SHALL verify CMD_BYTES=4, DATA_BYTES=2: read 32'h0102_xxxx → bytes 01,02 sent; rx AB,CD → read_data=16'hABCD.
REQ-037 SHALL verify stray rx_done in IDLE and tx_done in WAIT_RX are ignored; rx_done coincident with the timeout limit → read_err=0.
REQ-038 SHALL verify rst_n low during WAIT_TX of a write → all outputs at reset values immediately; next command completes normally.
